// File: rtl/global_avg_pool.sv
// global_avg_pool: computes the per-channel average over a full frame of
// 128-channel pixels. In ACCUM, every valid pixel is added into 128 wide
// accumulators. In SCALE, one channel per cycle is multiplied by a
// fixed-point reciprocal of the pixel count, then saturated. DONE produces
// a single-cycle Valid_Out pulse.
// Optional build macro: GAP_ROUND_EN selects round-half-up scaling.
// Without it, the scaling shift truncates toward minus infinity.
module global_avg_pool #(
  parameter int DATA_WIDHT  = 32,
  parameter int IMG_WIDHT   = 44,
  parameter int IMG_HEIGHT  = 44,
  parameter int RECIP       = 4333,
  parameter int RECIP_SHIFT = 23
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDHT*128-1:0] Data_In,
  input  logic                      Valid_In,
  output logic [DATA_WIDHT*128-1:0] Data_Out,
  output logic                      Valid_Out,
  output logic                      Overrun
);

  localparam int NCH     = 128;
  localparam int N       = IMG_WIDHT * IMG_HEIGHT;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int ACC_W   = DATA_WIDHT + CNT_W;
  // One extra bit so that RECIP can reach 2^RECIP_SHIFT, plus one sign bit.
  localparam int RECIP_W = RECIP_SHIFT + 2;
  localparam int PROD_W  = ACC_W + RECIP_W;

  localparam logic signed [RECIP_W-1:0] RECIP_S = RECIP_W'(RECIP);
  localparam logic signed [PROD_W-1:0]  SAT_MAX =
    {{(PROD_W-DATA_WIDHT+1){1'b0}}, {(DATA_WIDHT-1){1'b1}}};
  localparam logic signed [PROD_W-1:0]  SAT_MIN =
    {{(PROD_W-DATA_WIDHT+1){1'b1}}, {(DATA_WIDHT-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_pix_cnt;
  logic [6:0]               r_ch;
  logic signed [ACC_W-1:0]  r_acc [NCH];
  logic [DATA_WIDHT*NCH-1:0] r_data_out;
  logic                     r_overrun;

  logic                     w_accept;
  logic                     w_last_pix;
  logic                     w_valid_out;
  logic signed [ACC_W-1:0]  w_acc_sel;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_prod_adj;
  logic signed [PROD_W-1:0] w_shift;
  logic [DATA_WIDHT-1:0]    w_sat;

  // A pixel only counts while accumulating; pixels seen in SCALE or DONE are dropped.
  assign w_accept   = (r_state == ACCUM) && Valid_In;
  assign w_last_pix = w_accept && (r_pix_cnt == CNT_W'(N - 1));

  // Holds the state register; reset discards any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next_state;
  end

  // Computes the next state and the DONE pulse.
  always_comb begin
    w_next_state = r_state;
    w_valid_out  = 1'b0;
    case (r_state)
      ACCUM: if (w_last_pix) w_next_state = SCALE;
      SCALE: if (r_ch == 7'd127) w_next_state = DONE;
      DONE: begin
        w_valid_out  = 1'b1;
        w_next_state = ACCUM;
      end
      default: w_next_state = ACCUM;
    endcase
  end

  // Counts accepted pixels and wraps to zero on the last pixel of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt <= '0;
    end else if (w_accept) begin
      if (w_last_pix) r_pix_cnt <= '0;
      else            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
    end
  end

  // Walks the channel index through 0..127 during SCALE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_ch <= '0;
    else if (r_state == SCALE) r_ch <= r_ch + 7'd1;
    else                       r_ch <= '0;
  end

  // Sums sign-extended samples. Each accumulator is cleared as SCALE reads it,
  // so the next frame starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_accept)
          r_acc[c] <= r_acc[c] + ACC_W'($signed(Data_In[c*DATA_WIDHT +: DATA_WIDHT]));
        else if ((r_state == SCALE) && (r_ch == 7'(c)))
          r_acc[c] <= '0;
      end
    end
  end

  // Multiplies by the reciprocal, shifts and saturates the selected channel.
  assign w_acc_sel = r_acc[r_ch];
  assign w_prod    = PROD_W'(w_acc_sel) * PROD_W'(RECIP_S);
`ifdef GAP_ROUND_EN
  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) <<< (RECIP_SHIFT - 1);
  assign w_prod_adj = w_prod + ROUND_BIAS;
`else
  assign w_prod_adj = w_prod;
`endif
  assign w_shift = w_prod_adj >>> RECIP_SHIFT;

  // Clamps the scaled value into the signed output range so it cannot wrap.
  always_comb begin
    w_sat = w_shift[DATA_WIDHT-1:0];
    if (w_shift > SAT_MAX)      w_sat = SAT_MAX[DATA_WIDHT-1:0];
    else if (w_shift < SAT_MIN) w_sat = SAT_MIN[DATA_WIDHT-1:0];
  end

  // Writes one output channel per SCALE cycle. Other channels keep their last average.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out <= '0;
    end else if (r_state == SCALE) begin
      for (int c = 0; c < NCH; c++)
        if (r_ch == 7'(c)) r_data_out[c*DATA_WIDHT +: DATA_WIDHT] <= w_sat;
    end
  end

  // Sets a sticky flag when a pixel arrives while the block is not accepting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_overrun <= 1'b0;
    else if (Valid_In && (r_state != ACCUM))    r_overrun <= 1'b1;
  end

  assign Data_Out  = r_data_out;
  assign Valid_Out = w_valid_out;
  assign Overrun   = r_overrun;

endmodule

// File: tb/tb_global_avg_pool.sv
// Testbench for global_avg_pool.
// Each table row drives one whole frame. Constant rows are checked against
// hand-derived averages. Random rows are checked against a reference model
// that uses plain 64-bit arithmetic.
// Hand-written sequences cover the multi-cycle corner cases: overrun and
// reset in the middle of a frame or of SCALE.
module tb_global_avg_pool;

  localparam int DW    = 32;
  localparam int NCH   = 128;
  localparam int NPIX  = 1936;
  localparam int RECIP = 4333;
  localparam int RSH   = 23;
  localparam int LAT   = 128;
`ifdef GAP_ROUND_EN
  localparam int NEG3_EXP = -3;
`else
  localparam int NEG3_EXP = -4;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [DW*NCH-1:0]  Data_In;
  logic               Valid_In;
  logic [DW*NCH-1:0]  Data_Out;
  logic               Valid_Out;
  logic               Overrun;

  int     errors = 0;
  int     checks = 0;
  longint modelSum [NCH];
  logic [DW*NCH-1:0] midSnapshot;

  typedef struct {
    string name;
    int    mode;      // 0 constant, 1 channel index, 2 random full range, 3 random biased
    int    value;
    int    duty;      // percent of cycles with Valid_In high
    int    useModel;
    int    expMode;   // 0 constant expected, 1 expected equals channel index
    int    expValue;
  } vec_t;

  vec_t vecs [7];

  global_avg_pool dut (
    .clk      (clk),
    .rst      (rst),
    .Data_In  (Data_In),
    .Valid_In (Valid_In),
    .Data_Out (Data_Out),
    .Valid_Out(Valid_Out),
    .Overrun  (Overrun)
  );

  always #5 clk = ~clk;

  // Frame average: floor(sum * RECIP / 2^RSH), optionally rounded half up,
  // then clamped to the 32-bit signed range.
  function automatic longint modelAverage(input longint s);
    longint p;
    p = s * RECIP;
`ifdef GAP_ROUND_EN
    p = p + (longint'(1) << (RSH - 1));
`endif
    p = p >>> RSH;
    if (p > 64'sd2147483647)  p = 64'sd2147483647;
    if (p < -64'sd2147483648) p = -64'sd2147483648;
    return p;
  endfunction

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint chanOut(input int c);
    logic [DW-1:0] v;
    v = Data_Out[c*DW +: DW];
    return longint'($signed(v));
  endfunction

  // Drives numPix accepted pixels and returns just after the last accepting edge.
  task automatic applyStimulus(input int mode, input int value, input int duty, input int numPix);
    int accepted;
    int cycles;
    int v;
    accepted = 0;
    cycles   = 0;
    for (int c = 0; c < NCH; c++) modelSum[c] = 0;
    while (accepted < numPix && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (accepted == numPix / 2) midSnapshot = Data_Out;
      Valid_In = (int'($urandom_range(99)) < duty);
      for (int c = 0; c < NCH; c++) begin
        case (mode)
          0:       v = value;
          1:       v = c;
          2:       v = int'($urandom());
          default: v = int'($urandom_range(1000000)) - 200000;
        endcase
        if (!Valid_In) v = int'($urandom());
        Data_In[c*DW +: DW] = v;
        if (Valid_In) modelSum[c] += longint'(v);
      end
      @(posedge clk);
      if (Valid_In) accepted++;
    end
    if (accepted < numPix) begin
      check("stimulusBudget", accepted, numPix);
    end
  endtask

  // Counts edges from the last accepted pixel until Valid_Out.
  // Optionally pulses Valid_In during SCALE and DONE.
  task automatic waitValidOut(input int injectCycles, output int latency);
    int edges;
    bit found;
    edges = 0;
    found = 0;
    while (!found && edges < 400) begin
      @(negedge clk);
      if (Valid_Out) begin
        found = 1;
      end else begin
        Valid_In = (edges >= 10) && (edges < 10 + injectCycles);
        Data_In  = {NCH{32'd100}};
        @(posedge clk);
        edges++;
      end
    end
    latency  = found ? edges : -1;
    Valid_In = (injectCycles > 0) && found;
    @(posedge clk);
    @(negedge clk);
    Valid_In = 1'b0;
    check("validOutPulseWidth", Valid_Out, 0);
  endtask

  task automatic checkOutput(input string name, input int useModel, input int expMode, input int expValue);
    longint exp;
    for (int c = 0; c < NCH; c++) begin
      if (useModel != 0)    exp = modelAverage(modelSum[c]);
      else if (expMode == 1) exp = c;
      else                  exp = expValue;
      check($sformatf("%s_ch%0d", name, c), chanOut(c), exp);
    end
  endtask

  initial begin
    int lat;
    bit sawValid;

    vecs[0] = '{"all5",     0, 5,            100, 0, 0, 5};
    vecs[1] = '{"allNeg3",  0, -3,           100, 0, 0, NEG3_EXP};
    vecs[2] = '{"chanIdx",  1, 0,            50,  0, 1, 0};
    vecs[3] = '{"satMax",   0, 32'h7fffffff, 100, 0, 0, 32'h7fffffff};
    vecs[4] = '{"satMin",   0, 32'h80000000, 100, 0, 0, 32'h80000000};
    vecs[5] = '{"randFull", 2, 0,            70,  1, 0, 0};
    vecs[6] = '{"randBias", 3, 0,            40,  1, 0, 0};

    rst      = 1'b1;
    Valid_In = 1'b0;
    Data_In  = '0;
    repeat (2) @(negedge clk);
    check("resetValidOut", Valid_Out, 0);
    check("resetOverrun",  Overrun, 0);
    check("resetDataOutNonzero", longint'(|Data_Out), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].value, vecs[i].duty, NPIX);
      waitValidOut(0, lat);
      check({vecs[i].name, "_latency"}, lat, LAT);
      check({vecs[i].name, "_overrun"}, Overrun, 0);
      checkOutput(vecs[i].name, vecs[i].useModel, vecs[i].expMode, vecs[i].expValue);
    end

    $display("[TB] overrun sequence");
    applyStimulus(0, 5, 100, NPIX);
    waitValidOut(3, lat);
    check("ovr_latency", lat, LAT);
    check("ovr_flagSet", Overrun, 1);
    checkOutput("ovr_first", 0, 0, 5);
    applyStimulus(0, 9, 100, NPIX);
    waitValidOut(0, lat);
    check("ovr_secondLatency", lat, LAT);
    check("ovr_holdCh0",   longint'($signed(midSnapshot[0 +: DW])), 5);
    check("ovr_holdCh127", longint'($signed(midSnapshot[127*DW +: DW])), 5);
    check("ovr_flagSticky", Overrun, 1);
    checkOutput("ovr_second", 0, 0, 9);

    $display("[TB] reset mid-frame sequence");
    applyStimulus(0, 7, 100, 1000);
    @(negedge clk);
    Valid_In = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstAsyncOverrun", Overrun, 0);
    check("rstAsyncDataOutNonzero", longint'(|Data_Out), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 2, 100, NPIX);
    waitValidOut(0, lat);
    check("rstFrame_latency", lat, LAT);
    checkOutput("rstFrame", 0, 0, 2);

    $display("[TB] reset mid-scale sequence");
    applyStimulus(0, 4, 100, NPIX);
    @(negedge clk);
    Valid_In = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstScaleDataOutNonzero", longint'(|Data_Out), 0);
    sawValid = 0;
    repeat (200) begin
      @(negedge clk);
      if (Valid_Out) sawValid = 1;
    end
    check("rstScaleNoValidOut", sawValid, 0);
    applyStimulus(0, 6, 100, NPIX);
    waitValidOut(0, lat);
    check("rstScaleFrame_latency", lat, LAT);
    checkOutput("rstScaleFrame", 0, 0, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
